hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Sits beside the operand-forwarding logic and covers the hazards that forwarding cannot resolve:
  - load-use,
  - multi-cycle mul/div occupancy in EX,
  - data-memory wait states,
  - control redirects.
- Drives per-stage enable/flush, tracks mul/div busy with a watchdog, and keeps stall/flush performance counters.

Parameters:
- MD_TIMEOUT, 64, max cycles in MD_BUSY before forced exit.
- CNT_W, 32, width of performance counters (saturating).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination of instruction in EX
- if_id_rs1  in  5  rs1 of instruction in ID
- if_id_rs2  in  5  rs2 of instruction in ID
- if_id_use_rs1  in  1  ID instruction reads rs1
- if_id_use_rs2  in  1  ID instruction reads rs2
- ex_redirect  in  1  branch taken / jump resolved in EX
- ex_md_start  in  1  EX holds mul/div, unit starting
- md_done  in  1  mul/div result valid (1-cycle pulse)
- dmem_req  in  1  MEM stage access active
- dmem_ready  in  1  data memory completes access
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX load bubble
- ex_mem_en  out  1  EX/MEM enable
- ex_mem_flush  out  1  EX/MEM load bubble
- mem_wb_en  out  1  MEM/WB enable
- md_busy  out  1  state == MD_BUSY
- md_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  cycles with pc_en==0 (excluding reset)
- flush_cnt  out  CNT_W  redirect flush events

Behaviour:
- State register: RUN, MD_BUSY, MEM_WAIT.
  - All control outputs are combinational from state and inputs.
  - Counters and flags are registered.
- Default outputs: every enable = 1, every flush = 0.
- Reset (rst high at posedge):
  - state=RUN, counters=0, md_timeout=0, watchdog=0.
  - While rst is high, all enables are 0 and all flushes are 1, regardless of state.
- Hazard terms:
  - memstall = dmem_req && !dmem_ready.
  - loaduse = id_ex_memread && id_ex_rd!=0 && ((id_ex_rd==if_id_rs1 && if_id_use_rs1) || (id_ex_rd==if_id_rs2 && if_id_use_rs2)).
- Priority, evaluated in RUN each cycle:
  1. memstall:
     - All enables 0, no flushes.
     - Next state MEM_WAIT.
  2. ex_md_start:
     - pc_en, if_id_en, id_ex_en = 0.
     - ex_mem_flush=1.
     - Next MD_BUSY; watchdog cleared.
  3. ex_redirect:
     - if_id_flush=1, id_ex_flush=1, pc_en=1.
     - flush_cnt+1.
     - Overrides loaduse.
  4. loaduse:
     - pc_en=0, if_id_en=0, id_ex_flush=1 (one bubble, single cycle, stays RUN).
- MEM_WAIT:
  - All enables 0 while memstall.
  - When dmem_ready=1, outputs revert to RUN evaluation in that same cycle and next state is RUN.
  - A redirect or md_start held in EX is acted on only after release.
- MD_BUSY:
  - pc_en, if_id_en, id_ex_en = 0; ex_mem_flush=1; watchdog increments.
  - md_done=1:
    - ex_mem_en=1, ex_mem_flush=0 (result captured).
    - Next RUN.
    - ex_md_start must not re-trigger in the cycle after the return.
  - Watchdog reaches MD_TIMEOUT-1 without md_done:
    - md_timeout set (sticky until rst).
    - Next RUN with same outputs as the md_done exit.
  - memstall while in MD_BUSY: ignored (EX/MEM holds a bubble).
- md_done outside MD_BUSY is ignored.
- stall_cnt increments every non-reset cycle where pc_en==0. stall_cnt and flush_cnt saturate at all-ones.
- x0 is never a hazard source (id_ex_rd==0 blocks loaduse).

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5, use_rs2=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (memread=0) all enables 1; stall_cnt=1.
- Redirect + load-use in same cycle: ex_redirect=1 with a matching loaduse -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Mul/div: ex_md_start pulse, md_done 4 cycles later -> md_busy high 4 cycles, ex_mem_flush=1 for 4 cycles, stall_cnt=5, state RUN after.
- Watchdog: MD_TIMEOUT=8, md_done never -> md_timeout=1 after 8 cycles in MD_BUSY, return to RUN, flag stays until rst.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles -> all enables 0 for 3 cycles; ex_redirect held throughout -> flush applied in the dmem_ready cycle only, flush_cnt=1.
- Reset mid-MD_BUSY: assert rst for 1 cycle -> state RUN, counters 0, md_timeout 0; during rst all enables 0 and flushes 1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage enable/flush for hazards
// that forwarding cannot cover, plus a mul/div watchdog and stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = $clog2(MD_TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            md_ret;
  logic            memstall, loaduse, md_start_ok, wd_expired;
  logic            md_exit, flush_evt, wd_clear;

  assign memstall    = dmem_req && !dmem_ready;
  assign loaduse     = id_ex_memread && (id_ex_rd != 5'd0) &&
                       (((id_ex_rd == if_id_rs1) && if_id_use_rs1) ||
                        ((id_ex_rd == if_id_rs2) && if_id_use_rs2));
  // The mul/div stays in EX for one cycle after its result is captured; don't restart it.
  assign md_start_ok = ex_md_start && !md_ret;
  assign wd_expired  = (wd_cnt == WD_W'(MD_TIMEOUT - 1));
  assign md_busy     = (state == MD_BUSY);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_nxt    = state;
    md_exit      = 1'b0;
    flush_evt    = 1'b0;
    wd_clear     = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_nxt    = RUN;
    end else begin
      case (state)
        MD_BUSY: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          if (md_done || wd_expired) begin
            ex_mem_flush = 1'b0;
            md_exit      = 1'b1;
            state_nxt    = RUN;
          end
        end
        // MEM_WAIT releases into a full RUN evaluation in the dmem_ready cycle.
        default: begin
          if (memstall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_nxt = MEM_WAIT;
          end else if (md_start_ok) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            wd_clear     = 1'b1;
            state_nxt    = MD_BUSY;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
            state_nxt   = RUN;
          end else begin
            state_nxt = RUN;
            if (loaduse) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wd_cnt     <= '0;
      md_ret     <= 1'b0;
      md_timeout <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      md_ret <= md_exit;
      if (wd_clear)
        wd_cnt <= '0;
      else if (md_busy && !md_exit)
        wd_cnt <= wd_cnt + 1'b1;
      if (md_exit && !md_done)
        md_timeout <= 1'b1;
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a cycle-level reference model checks every
// output each cycle, and literal expectations pin the key scenarios.
module tb_hazard_stall_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst;
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       redirect;
    logic       md_start;
    logic       md_done;
    logic       dreq;
    logic       drdy;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, id_ex_memread, if_id_use_rs1, if_id_use_rs2;
  logic [4:0]       id_ex_rd, if_id_rs1, if_id_rs2;
  logic             ex_redirect, ex_md_start, md_done, dmem_req, dmem_ready;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, ex_mem_flush, mem_wb_en, md_busy, md_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .ex_redirect(ex_redirect), .ex_md_start(ex_md_start), .md_done(md_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en),
    .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: only "busy or not" matters; a memory wait looks like RUN from outside.
  bit m_valid = 0, m_busy = 0, m_ret = 0, m_tmo = 0;
  int m_wd = 0, m_stall = 0, m_flush = 0;

  int n_vec = 0, n_cmp = 0, n_fail = 0;
  int seen_busy = 0, seen_exmem_flush = 0, seen_ifid_flush = 0, seen_all_stall = 0;
  logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic s_mem_wb_en, s_md_busy;

  function automatic vec_t idle();
    vec_t v;
    v.rst = 0; v.memread = 0; v.rd = 0; v.rs1 = 0; v.rs2 = 0; v.use1 = 0; v.use2 = 0;
    v.redirect = 0; v.md_start = 0; v.md_done = 0; v.dreq = 0; v.drdy = 0;
    return v;
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic e_pc, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en;
    logic e_ifid_fl, e_idex_fl, e_exmem_fl;
    bit memstall, loaduse, start, done;
    rst = v.rst; id_ex_memread = v.memread; id_ex_rd = v.rd;
    if_id_rs1 = v.rs1; if_id_rs2 = v.rs2; if_id_use_rs1 = v.use1; if_id_use_rs2 = v.use2;
    ex_redirect = v.redirect; ex_md_start = v.md_start; md_done = v.md_done;
    dmem_req = v.dreq; dmem_ready = v.drdy;
    n_vec++;
    @(negedge clk);

    memstall = v.dreq && !v.drdy;
    loaduse  = v.memread && v.rd != 0 &&
               ((v.rd == v.rs1 && v.use1) || (v.rd == v.rs2 && v.use2));
    start    = v.md_start && !m_ret;
    done     = v.md_done || (m_wd == MD_TIMEOUT - 1);
    {e_pc, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 5'b11111;
    {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b000;
    if (v.rst) begin
      {e_pc, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 5'b00000;
      {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b111;
    end else if (m_busy) begin
      {e_pc, e_ifid_en, e_idex_en} = 3'b000;
      e_exmem_fl = !done;
    end else if (memstall) begin
      {e_pc, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 5'b00000;
    end else if (start) begin
      {e_pc, e_ifid_en, e_idex_en} = 3'b000;
      e_exmem_fl = 1;
    end else if (v.redirect) begin
      {e_ifid_fl, e_idex_fl} = 2'b11;
    end else if (loaduse) begin
      {e_pc, e_ifid_en} = 2'b00;
      e_idex_fl = 1;
    end

    checkOutput("pc_en", {31'd0, pc_en}, {31'd0, e_pc});
    checkOutput("if_id_en", {31'd0, if_id_en}, {31'd0, e_ifid_en});
    checkOutput("id_ex_en", {31'd0, id_ex_en}, {31'd0, e_idex_en});
    checkOutput("ex_mem_en", {31'd0, ex_mem_en}, {31'd0, e_exmem_en});
    checkOutput("mem_wb_en", {31'd0, mem_wb_en}, {31'd0, e_memwb_en});
    checkOutput("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_ifid_fl});
    checkOutput("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_idex_fl});
    checkOutput("ex_mem_flush", {31'd0, ex_mem_flush}, {31'd0, e_exmem_fl});
    if (m_valid) begin
      checkOutput("md_busy", {31'd0, md_busy}, {31'd0, m_busy});
      checkOutput("md_timeout", {31'd0, md_timeout}, {31'd0, m_tmo});
      checkOutput("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, m_stall);
      checkOutput("flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, m_flush);
    end

    s_pc_en = pc_en; s_if_id_en = if_id_en; s_if_id_flush = if_id_flush;
    s_id_ex_flush = id_ex_flush; s_ex_mem_flush = ex_mem_flush;
    s_mem_wb_en = mem_wb_en; s_md_busy = md_busy;
    if (md_busy === 1'b1) seen_busy++;
    if (ex_mem_flush === 1'b1) seen_exmem_flush++;
    if (if_id_flush === 1'b1) seen_ifid_flush++;
    if (!v.rst && {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} === 5'b00000)
      seen_all_stall++;

    if (v.rst) begin
      m_valid = 1; m_busy = 0; m_ret = 0; m_tmo = 0; m_wd = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc) m_stall = sat_inc(m_stall);
      if (m_busy) begin
        if (done) begin
          m_busy = 0; m_ret = 1;
          if (!v.md_done) m_tmo = 1;
        end else begin
          m_wd++; m_ret = 0;
        end
      end else begin
        m_ret = 0;
        if (!memstall && start) begin
          m_busy = 1; m_wd = 0;
        end else if (!memstall && v.redirect) begin
          m_flush = sat_inc(m_flush);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got hang, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vec_t v;
    v = idle(); v.rst = 1;
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("reset_pc_en", {31'd0, s_pc_en}, 32'd0);
    checkOutput("reset_if_id_flush", {31'd0, s_if_id_flush}, 32'd1);
    checkOutput("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("reset_md_timeout", {31'd0, md_timeout}, 32'd0);
    applyStimulus(idle());

    // Load-use on rs2: one bubble, then free flow.
    v = idle(); v.memread = 1; v.rd = 5; v.rs2 = 5; v.use2 = 1;
    applyStimulus(v);
    checkOutput("lu_pc_en", {31'd0, s_pc_en}, 32'd0);
    checkOutput("lu_if_id_en", {31'd0, s_if_id_en}, 32'd0);
    checkOutput("lu_id_ex_flush", {31'd0, s_id_ex_flush}, 32'd1);
    applyStimulus(idle());
    checkOutput("lu_after_pc_en", {31'd0, s_pc_en}, 32'd1);
    checkOutput("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // Redirect overrides a simultaneous load-use.
    v = idle(); v.memread = 1; v.rd = 5; v.rs1 = 5; v.use1 = 1; v.redirect = 1;
    applyStimulus(v);
    checkOutput("rd_pc_en", {31'd0, s_pc_en}, 32'd1);
    checkOutput("rd_if_id_flush", {31'd0, s_if_id_flush}, 32'd1);
    checkOutput("rd_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    checkOutput("rd_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // x0 destination never stalls.
    v = idle(); v.memread = 1; v.rd = 0; v.rs1 = 0; v.use1 = 1;
    applyStimulus(v);
    checkOutput("x0_pc_en", {31'd0, s_pc_en}, 32'd1);

    // Mul/div: start, done four cycles later, start still visible the cycle after.
    seen_busy = 0; seen_exmem_flush = 0;
    v = idle(); v.md_start = 1;
    for (int i = 0; i < 4; i++) applyStimulus(v);
    v.md_done = 1;
    applyStimulus(v);
    v.md_done = 0;
    applyStimulus(v);
    checkOutput("md_noretrigger_busy", {31'd0, s_md_busy}, 32'd0);
    checkOutput("md_noretrigger_pc_en", {31'd0, s_pc_en}, 32'd1);
    applyStimulus(idle());
    checkOutput("md_busy_cycles", seen_busy, 32'd4);
    checkOutput("md_flush_cycles", seen_exmem_flush, 32'd4);
    checkOutput("md_stall_cnt", {28'd0, stall_cnt}, 32'd6);

    // Memory wait with redirect held: flush only in the release cycle.
    seen_all_stall = 0; seen_ifid_flush = 0;
    v = idle(); v.dreq = 1; v.redirect = 1;
    for (int i = 0; i < 3; i++) applyStimulus(v);
    v.drdy = 1;
    applyStimulus(v);
    checkOutput("mw_release_pc_en", {31'd0, s_pc_en}, 32'd1);
    applyStimulus(idle());
    checkOutput("mw_stall_cycles", seen_all_stall, 32'd3);
    checkOutput("mw_flush_events", seen_ifid_flush, 32'd1);
    checkOutput("mw_flush_cnt", {28'd0, flush_cnt}, 32'd2);
    checkOutput("mw_stall_cnt", {28'd0, stall_cnt}, 32'd9);

    // Watchdog: md_done never arrives; stall_cnt runs into saturation.
    seen_busy = 0;
    v = idle(); v.md_start = 1;
    applyStimulus(v);
    for (int i = 0; i < 7; i++) applyStimulus(idle());
    checkOutput("wd_not_yet", {31'd0, md_timeout}, 32'd0);
    applyStimulus(idle());
    checkOutput("wd_timeout", {31'd0, md_timeout}, 32'd1);
    checkOutput("wd_busy_cycles", seen_busy, 32'd8);
    checkOutput("wd_stall_sat", {28'd0, stall_cnt}, 32'd15);
    v = idle(); v.md_done = 1;
    applyStimulus(v);
    applyStimulus(idle());
    checkOutput("wd_sticky", {31'd0, md_timeout}, 32'd1);
    checkOutput("wd_stray_done_busy", {31'd0, s_md_busy}, 32'd0);

    // flush_cnt saturation.
    v = idle(); v.redirect = 1;
    for (int i = 0; i < 13; i++) applyStimulus(v);
    checkOutput("fc_at_max", {28'd0, flush_cnt}, 32'd15);
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("fc_sat", {28'd0, flush_cnt}, 32'd15);

    // Reset in the middle of a mul/div.
    v = idle(); v.md_start = 1;
    applyStimulus(v);
    applyStimulus(idle());
    applyStimulus(idle());
    v = idle(); v.rst = 1;
    applyStimulus(v);
    checkOutput("rstmd_pc_en", {31'd0, s_pc_en}, 32'd0);
    checkOutput("rstmd_mem_wb_en", {31'd0, s_mem_wb_en}, 32'd0);
    checkOutput("rstmd_id_ex_flush", {31'd0, s_id_ex_flush}, 32'd1);
    checkOutput("rstmd_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("rstmd_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    checkOutput("rstmd_md_timeout", {31'd0, md_timeout}, 32'd0);
    checkOutput("rstmd_md_busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(idle());
    checkOutput("rstmd_after_pc_en", {31'd0, s_pc_en}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
